imm_ext_pipe: RTL
=================

# imm_ext_pipe

Registered, parametrised immediate-extension stage for the pipelined datapath. It accepts an immediate field plus an extension opcode, and produces the extended word one cycle later. Valid/ready handshakes on both sides and a 2-entry skid buffer let the ID stage stall without losing operands. Sits between instruction decode and the ID/EX pipeline register.

## Interface
- `IMM_W`, default 16: width of the immediate field.
- `DATA_W`, default 32: width of the extended result. Legal values satisfy DATA_W ≥ IMM_W+2.
- `TAG_W`, default 5: width of the sideband tag (e.g. destination register) carried alongside the data.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous pipeline flush.
- `in_valid` input 1: upstream offers an operand.
- `in_ready` output 1: stage can accept an operand this cycle.
- `in_imm` input IMM_W: immediate field.
- `in_op` input 2: extension mode.
- `in_tag` input TAG_W: sideband tag, passed through unchanged.
- `out_valid` output 1: result available.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output DATA_W: extended result.
- `out_tag` output TAG_W: tag belonging to `out_data`.
- `out_err` output 1: the result came from an illegal or disabled opcode.

## Operation
- Extension modes, with s = in_imm[IMM_W-1]:
  - op 0, zero extend: {(DATA_W-IMM_W)'0, imm}.
  - op 1, sign extend: {(DATA_W-IMM_W){s}, imm}.
  - op 2, branch offset: {(DATA_W-IMM_W-2){s}, imm, 2'b00}.
  - op 3, upper load: {imm, (DATA_W-IMM_W)'0}. Only when `EXT_LUI_EN` is defined (see Configuration).
  - Illegal or disabled op: out_data = all ones and out_err = 1. out_err = 0 for every legal op.
- Storage is a main register (M) feeding the outputs and a skid register (S). Each holds data, tag, err and a valid bit.
- Transfers:
  - An input transfer happens on in_valid & in_ready.
  - An output transfer happens on out_valid & out_ready.
- Per edge, with M valid = out_valid:
  - M empty, or M drained this cycle: M loads from S if S is valid, otherwise from the input if it transfers. S is cleared after it moves into M.
  - M full, not drained, and an input transfer: the input goes to S.
- in_ready = ~S.valid, taken directly from the register with no combinational path from out_ready.
- Ordering is strictly FIFO. No operand is dropped or duplicated.
- flush wins over everything:
  - M.valid and S.valid clear at the edge.
  - Any input offered in the flush cycle is discarded.
  - in_ready = 1 in the next cycle.
- Reset values: out_valid=0, in_ready=1, out_data=0, out_tag=0, out_err=0, S cleared.
- A reset asserted mid-operation discards all buffered entries immediately, without waiting for a clock edge.

## Timing
- Latency is exactly one cycle: an operand accepted at edge N appears on outputs after edge N when the stage was empty.
- Sustained throughput is 1 per cycle while out_ready = 1.
- out_ready low with M full:
  - One more operand is absorbed into S.
  - in_ready drops after that edge.
  - Re-asserting out_ready raises in_ready one cycle later.
- out_data, out_tag, out_err and out_valid are register outputs with no combinational input→output path.
- While out_valid=1 & out_ready=0, out_data, out_tag and out_err hold stable.

## Configuration
- `EXT_LUI_EN` defined: op 3 produces the upper-load result with out_err=0.
- `EXT_LUI_EN` undefined: op 3 is illegal and gives all ones with out_err=1. The op-3 datapath mux leg is not synthesised.

## Test plan
- **Modes:** IMM_W=16/DATA_W=32, out_ready=1, in_imm=16'h8004 with op 0/1/2 → out_data 0000_8004 / FFFF_8004 / FFFE_0010 in consecutive cycles after one-cycle latency; out_err=0.
- **Upper load:** op 3 with in_imm=16'h1234 → 1234_0000 and err 0 with `EXT_LUI_EN`; FFFF_FFFF and err 1 without it.
- **Backpressure:** stream tags 1..6 with out_ready=0 for cycles 2–4 → in_ready low from cycle 3; output sequence is tags 1..6 in order with none lost; data stable while stalled.
- **Flush:** M and S both full, flush=1 with in_valid=1 → next cycle out_valid=0 and in_ready=1; the offered operand never appears.
- **Reset:** reset asserted between clock edges while full → out_valid=0, out_data=0, in_ready=1 immediately; operation resumes normally after release.
- **Parametrisation:** IMM_W=8/DATA_W=16, in_imm=8'hF0 op 2 → 16'hFFC0.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe
// Registered immediate-extension stage between instruction decode and the
// ID/EX pipeline register. Each operand is extended one cycle after it is
// accepted. A main register (M) drives the outputs and a skid register (S)
// catches one extra operand when downstream stalls, so in_ready can come
// straight from a flop.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous flush; drops M, S and any operand offered that cycle
//   in_valid   upstream offers an operand
//   in_ready   stage can accept an operand (= ~S.valid)
//   in_imm     immediate field, IMM_W bits
//   in_op      extension mode: 0 zero, 1 sign, 2 branch offset, 3 upper load
//   in_tag     sideband tag carried alongside the data
//   out_valid  result available (= M.valid)
//   out_ready  downstream accepts the result
//   out_data   extended result, DATA_W bits
//   out_tag    tag belonging to out_data
//   out_err    result came from an illegal or disabled opcode
//
// Configuration macro
//   EXT_LUI_EN  when defined, op 3 produces {imm, zeros}; otherwise op 3 is
//               illegal (all ones, out_err=1) and its mux leg is not built.
//
// Parameters: IMM_W, DATA_W (must satisfy DATA_W >= IMM_W+2), TAG_W.

module imm_ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [TAG_W-1:0]  m_tag;
  logic              m_err;

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [TAG_W-1:0]  s_tag;
  logic              s_err;

  logic [DATA_W-1:0] ext_data;
  logic              ext_err;
  logic              sgn;
  logic              in_xfer;
  logic              m_open;

  assign sgn = in_imm[IMM_W-1];

  always_comb begin
    ext_data = '1;
    ext_err  = 1'b1;
    case (in_op)
      2'd0: begin
        ext_data = {{(DATA_W-IMM_W){1'b0}}, in_imm};
        ext_err  = 1'b0;
      end
      2'd1: begin
        ext_data = {{(DATA_W-IMM_W){sgn}}, in_imm};
        ext_err  = 1'b0;
      end
      2'd2: begin
        ext_data = {{(DATA_W-IMM_W-2){sgn}}, in_imm, 2'b00};
        ext_err  = 1'b0;
      end
`ifdef EXT_LUI_EN
      2'd3: begin
        ext_data = {in_imm, {(DATA_W-IMM_W){1'b0}}};
        ext_err  = 1'b0;
      end
`endif
      default: begin
      end
    endcase
  end

  // in_ready depends only on the skid flag, so there is never a path from
  // out_ready to in_ready. While S is full no input can transfer, which is
  // why the S->M move never collides with a new operand.
  assign in_ready = ~s_valid;
  assign in_xfer  = in_valid & ~s_valid;
  // M can take a new entry this edge if it is empty or being drained.
  assign m_open   = ~m_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_tag   <= '0;
      m_err   <= 1'b0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_tag   <= '0;
      s_err   <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_open) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_tag   <= s_tag;
        m_err   <= s_err;
        s_valid <= 1'b0;
      end else if (in_xfer) begin
        m_valid <= 1'b1;
        m_data  <= ext_data;
        m_tag   <= in_tag;
        m_err   <= ext_err;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      s_valid <= 1'b1;
      s_data  <= ext_data;
      s_tag   <= in_tag;
      s_err   <= ext_err;
    end
  end

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_tag   = m_tag;
  assign out_err   = m_err;

endmodule
